// File: rtl/palette_pkg.sv
// Shared types and constants for the writable VGA colour palette.
// Optional build macro: PALETTE_FADE_EN (adds a per-frame fade stage).
package palette_pkg;

    localparam int PAL_IDX_W      = 6;
    localparam int PAL_CH_W       = 4;
    localparam int PAL_BANKS      = 2;
    localparam int PAL_TRANSP_IDX = 0;

`ifdef PALETTE_FADE_EN
    localparam int PAL_LATENCY = 3;
`else
    localparam int PAL_LATENCY = 2;
`endif

    typedef struct packed {
        logic [PAL_CH_W-1:0] r;
        logic [PAL_CH_W-1:0] g;
        logic [PAL_CH_W-1:0] b;
    } rgb_t;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } pal_state_e;

    // Bank select width; a single bank still carries a 1-bit (always zero) field.
    function automatic int bank_addr_w(input int banks);
        if (banks > 1) begin
            return $clog2(banks);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/palette_bank_mem.sv
// Simple dual-port palette store: one write port, one registered read port.
// Read-before-write on a same-address collision, no reset so it maps to block RAM.
module palette_bank_mem #(
    parameter int AW    = 7,
    parameter int DW    = 12,
    parameter int DEPTH = 128
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [0:DEPTH-1];
    logic [DW-1:0] rdata_r;

    // Write port: data lands on the clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; a colliding write is not yet visible here.
    always_ff @(posedge clk) begin
        rdata_r <= mem_r[raddr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/palette_bank_ram.sv
// Multi-bank colour palette: index -> RGB lookup, runtime loader, frame-synced bank swap.
// Optional build macro: PALETTE_FADE_EN adds fade_level and one extra pipeline stage.
module palette_bank_ram
    import palette_pkg::*;
#(
    parameter int  IDX_W      = PAL_IDX_W,
    parameter int  CH_W       = PAL_CH_W,
    parameter int  BANKS      = PAL_BANKS,
    parameter int  TRANSP_IDX = PAL_TRANSP_IDX,
    localparam int BANK_W     = bank_addr_w(BANKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [BANK_W-1:0] bank_req,
`ifdef PALETTE_FADE_EN
    input  logic [3:0]        fade_level,
`endif
    input  logic              wr_en,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [3*CH_W-1:0] wr_rgb,
    output logic              wr_ready,
    input  logic              rd_valid,
    input  logic [IDX_W-1:0]  rd_index,
    output logic              out_valid,
    output logic [CH_W-1:0]   red,
    output logic [CH_W-1:0]   green,
    output logic [CH_W-1:0]   blue,
    output logic              transparent,
    output logic [BANK_W-1:0] active_bank
);

    localparam int                AW        = BANK_W + IDX_W;
    localparam int                DEPTH     = BANKS * (2 ** IDX_W);
    localparam int                DW        = 3 * CH_W;
    localparam logic [AW-1:0]     LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [BANK_W-1:0] BANK_MASK = BANK_W'(BANKS - 1);
    localparam logic [IDX_W-1:0]  TRANSP    = IDX_W'(TRANSP_IDX);

    pal_state_e        state_r;
    pal_state_e        state_next_s;
    logic [AW-1:0]     init_cnt_r;
    logic              wr_ready_r;
    logic [BANK_W-1:0] active_bank_r;

    logic              mem_we_s;
    logic [AW-1:0]     mem_waddr_s;
    logic [DW-1:0]     mem_wdata_s;
    logic [AW-1:0]     mem_raddr_s;
    logic [DW-1:0]     mem_rdata_s;
    logic [DW-1:0]     rd_data_s;

    logic              s1_valid_r;
    logic              s1_transp_r;
    logic              s1_init_r;
    logic              out_valid_r;
    logic              transparent_r;
    logic [DW-1:0]     colour_r;

    // Next-state logic: INIT walks every entry once, then RUN forever.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            INIT: begin
                if (init_cnt_r == LAST_ADDR) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = INIT;
                end
            end
            RUN:     state_next_s = RUN;
            default: state_next_s = INIT;
        endcase
    end

    // State, clear-walk counter and loader-ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= INIT;
            init_cnt_r <= '0;
            wr_ready_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            wr_ready_r <= (state_next_s == RUN);
            if (state_r == INIT) begin
                init_cnt_r <= init_cnt_r + AW'(1);
            end
        end
    end

    // Write port owner: clear walk during INIT, loader afterwards (loader dropped in INIT).
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = '0;
        if (state_r == INIT) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = init_cnt_r;
            mem_wdata_s = '0;
        end else begin
            mem_we_s    = wr_en;
            mem_waddr_s = {wr_bank & BANK_MASK, wr_index};
            mem_wdata_s = wr_rgb;
        end
    end

    assign mem_raddr_s = {active_bank_r & BANK_MASK, rd_index};

    palette_bank_mem #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (mem_waddr_s),
        .wdata (mem_wdata_s),
        .raddr (mem_raddr_s),
        .rdata (mem_rdata_s)
    );

`ifdef PALETTE_FADE_EN
    logic [3:0] fade_r;

    // Scale one channel by (level+1)/16.
    function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0] ch, input logic [3:0] lvl);
        logic [CH_W+4:0] prod;
        prod = (CH_W+5)'(ch) * (CH_W+5)'({1'b0, lvl} + 5'd1);
        return prod[CH_W+3:4];
    endfunction
`endif

    // Display bank (and fade level) only change at frame start for tear-free swaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_bank_r <= '0;
`ifdef PALETTE_FADE_EN
            fade_r        <= 4'd15;
`endif
        end else if (frame_start) begin
            active_bank_r <= bank_req & BANK_MASK;
`ifdef PALETTE_FADE_EN
            fade_r        <= fade_level;
`endif
        end
    end

    // Stage 1: track request alongside the RAM read; INIT lookups are forced black.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_transp_r <= 1'b0;
            s1_init_r   <= 1'b0;
        end else begin
            s1_valid_r  <= rd_valid;
            s1_transp_r <= (rd_index == TRANSP);
            s1_init_r   <= (state_r == INIT);
        end
    end

    assign rd_data_s = s1_init_r ? '0 : mem_rdata_s;

`ifdef PALETTE_FADE_EN
    logic          s2_valid_r;
    logic          s2_transp_r;
    logic [DW-1:0] s2_rgb_r;

    // Stage 2: hold the raw colour so the fade multiply gets its own cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r  <= 1'b0;
            s2_transp_r <= 1'b0;
            s2_rgb_r    <= '0;
        end else begin
            s2_valid_r  <= s1_valid_r;
            s2_transp_r <= s1_transp_r;
            s2_rgb_r    <= rd_data_s;
        end
    end

    // Output stage: faded colour; outputs hold when no lookup arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r   <= 1'b0;
            transparent_r <= 1'b0;
            colour_r      <= '0;
        end else begin
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                transparent_r <= s2_transp_r;
                colour_r      <= {fade_ch(s2_rgb_r[3*CH_W-1:2*CH_W], fade_r),
                                  fade_ch(s2_rgb_r[2*CH_W-1:CH_W],   fade_r),
                                  fade_ch(s2_rgb_r[CH_W-1:0],        fade_r)};
            end
        end
    end
`else
    // Output stage: colour straight from the RAM; outputs hold when no lookup arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r   <= 1'b0;
            transparent_r <= 1'b0;
            colour_r      <= '0;
        end else begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                transparent_r <= s1_transp_r;
                colour_r      <= rd_data_s;
            end
        end
    end
`endif

    assign wr_ready    = wr_ready_r;
    assign out_valid   = out_valid_r;
    assign transparent = transparent_r;
    assign red         = colour_r[3*CH_W-1:2*CH_W];
    assign green       = colour_r[2*CH_W-1:CH_W];
    assign blue        = colour_r[CH_W-1:0];
    assign active_bank = active_bank_r;

endmodule

// File: tb/tb_palette_bank_ram.sv
// Directed self-checking bench for palette_bank_ram (IDX_W=6, CH_W=4, BANKS=2).
module tb_palette_bank_ram;

`ifdef PALETTE_FADE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [0:0]  bank_req;
    logic        wr_en;
    logic [0:0]  wr_bank;
    logic [5:0]  wr_index;
    logic [11:0] wr_rgb;
    logic        wr_ready;
    logic        rd_valid;
    logic [5:0]  rd_index;
    logic        out_valid;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        transparent;
    logic [0:0]  active_bank;
`ifdef PALETTE_FADE_EN
    logic [3:0]  fade_level;
`endif

    int checks   = 0;
    int failures = 0;
    int n;

    palette_bank_ram dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .bank_req    (bank_req),
`ifdef PALETTE_FADE_EN
        .fade_level  (fade_level),
`endif
        .wr_en       (wr_en),
        .wr_bank     (wr_bank),
        .wr_index    (wr_index),
        .wr_rgb      (wr_rgb),
        .wr_ready    (wr_ready),
        .rd_valid    (rd_valid),
        .rd_index    (rd_index),
        .out_valid   (out_valid),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .transparent (transparent),
        .active_bank (active_bank)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] pat(input int i);
        logic [5:0] k;
        k = 6'(i);
        return {k[3:0] ^ 4'h5, 2'b10, k[5:4], 4'hF - k[3:0]};
    endfunction

    task automatic wr(input logic b, input logic [5:0] idx, input logic [11:0] d);
        wr_en    = 1'b1;
        wr_bank  = b;
        wr_index = idx;
        wr_rgb   = d;
        step();
        wr_en    = 1'b0;
    endtask

    task automatic fs(input logic b);
        bank_req    = b;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [5:0] idx, input logic [11:0] exp, input logic exp_t);
        rd_valid = 1'b1;
        rd_index = idx;
        step();
        rd_valid = 1'b0;
        repeat (LAT - 1) step();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_rgb"}, 32'({red, green, blue}), 32'(exp));
        check({tag, "_transp"}, 32'(transparent), 32'(exp_t));
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        bank_req    = 1'b0;
        wr_en       = 1'b0;
        wr_bank     = 1'b0;
        wr_index    = 6'd0;
        wr_rgb      = 12'h000;
        rd_valid    = 1'b0;
        rd_index    = 6'd0;
`ifdef PALETTE_FADE_EN
        fade_level  = 4'd15;
`endif
        repeat (3) step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_rgb", 32'({red, green, blue}), 32'h0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_active_bank", 32'(active_bank), 32'd0);
        check("rst_transp", 32'(transparent), 32'd0);

        // Release reset; lookups during INIT return black.
        rst      = 1'b0;
        rd_valid = 1'b1;
        rd_index = 6'd3;
        step();
        check("init_lat_early", 32'(out_valid), 32'd0);
        rd_index = 6'd0;
        step();
        rd_valid = 1'b0;
        repeat (LAT - 2) step();
        check("init_rd3_valid", 32'(out_valid), 32'd1);
        check("init_rd3_rgb", 32'({red, green, blue}), 32'h0);
        check("init_rd3_transp", 32'(transparent), 32'd0);
        step();
        check("init_rd0_valid", 32'(out_valid), 32'd1);
        check("init_rd0_transp", 32'(transparent), 32'd1);
        n = LAT + 1;
        check("init_not_ready", 32'(wr_ready), 32'd0);
        // A loader write after the clear walk passed entry 9 must still be dropped.
        while (!wr_ready && n < 300) begin
            wr_en    = (n == 100);
            wr_bank  = 1'b0;
            wr_index = 6'd9;
            wr_rgb   = 12'hABC;
            step();
            n++;
        end
        wr_en = 1'b0;
        check("init_cycles", 32'(n), 32'd128);

        // Basic write then lookup in bank 0.
        wr(1'b0, 6'd5, 12'hE4B);
        fs(1'b0);
        lookup("b0_idx5", 6'd5, 12'hE4B, 1'b0);
        lookup("init_write_dropped", 6'd9, 12'h000, 1'b0);

        // Double buffer: write bank 1 while showing bank 0, then swap.
        wr(1'b1, 6'd5, 12'h19B);
        lookup("b0_still", 6'd5, 12'hE4B, 1'b0);
        fs(1'b1);
        check("swap_active_bank", 32'(active_bank), 32'd1);
        lookup("b1_idx5", 6'd5, 12'h19B, 1'b0);

        // Same-cycle write/read collision returns the old data.
        wr_en    = 1'b1;
        wr_bank  = 1'b1;
        wr_index = 6'd7;
        wr_rgb   = 12'hFFF;
        rd_valid = 1'b1;
        rd_index = 6'd7;
        step();
        wr_en = 1'b0;
        step();
        rd_valid = 1'b0;
        repeat (LAT - 2) step();
        check("coll_old_valid", 32'(out_valid), 32'd1);
        check("coll_old_rgb", 32'({red, green, blue}), 32'h000);
        step();
        check("coll_new_valid", 32'(out_valid), 32'd1);
        check("coll_new_rgb", 32'({red, green, blue}), 32'hFFF);

        lookup("transp_idx0", 6'd0, 12'h000, 1'b1);

        // Fill bank 1 back-to-back, then stream all 64 indices.
        for (int i = 0; i < 64; i++) begin
            wr_en    = 1'b1;
            wr_bank  = 1'b1;
            wr_index = 6'(i);
            wr_rgb   = pat(i);
            step();
        end
        wr_en = 1'b0;
        for (int k = 0; k < 64 + LAT - 1; k++) begin
            rd_valid = (k < 64);
            rd_index = 6'(k);
            step();
            if (k >= LAT - 1) begin
                check("sweep_valid", 32'(out_valid), 32'd1);
                check("sweep_rgb", 32'({red, green, blue}), 32'(pat(k - (LAT - 1))));
                check("sweep_transp", 32'(transparent), 32'((k - (LAT - 1)) == 0));
            end
        end
        rd_valid = 1'b0;
        step();
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_hold_rgb", 32'({red, green, blue}), 32'(pat(63)));

        // Reset mid-stream: async flush, INIT restarts.
        rd_valid = 1'b1;
        rd_index = 6'd5;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_rgb", 32'({red, green, blue}), 32'h0);
        check("mid_rst_ready", 32'(wr_ready), 32'd0);
        check("mid_rst_bank", 32'(active_bank), 32'd0);
        rd_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        n   = 0;
        while (!wr_ready && n < 300) begin
            step();
            n++;
        end
        check("reinit_cycles", 32'(n), 32'd128);
        lookup("reinit_b0", 6'd5, 12'h000, 1'b0);
        fs(1'b1);
        lookup("reinit_b1", 6'd5, 12'h000, 1'b0);

`ifdef PALETTE_FADE_EN
        wr(1'b0, 6'd5, 12'hE4B);
        fade_level = 4'd7;
        fs(1'b0);
        lookup("fade7", 6'd5, 12'h725, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
